// File: rtl/param_counter_pkg.sv
// Shared types and constants for the parametrised up/down counter.
// Optional capture feature: PARAM_COUNTER_CAPTURE_EN.
package param_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/param_updown_counter_prescaler.sv
// Step-rate prescaler: one tick every div+1 enabled cycles.
// The compare is ">=" so a shrinking div takes effect on the very next compare
// instead of letting the counter run around its full range.
module counter_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick_c
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick_c = enable && (cnt >= div);

  // Divider count: cleared on request, restarts after each tick.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (tick_c) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised modulo-MODULUS up/down counter with prescaler, clear, load,
// one-shot mode and terminal-count pulse.
// Optional capture register enabled by macro PARAM_COUNTER_CAPTURE_EN.
module param_updown_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MODULUS    = 256,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  one_shot,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] presc_div,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done,
  output logic                  busy
`ifdef PARAM_COUNTER_CAPTURE_EN
  ,
  input  logic                  capture,
  output logic [WIDTH-1:0]      cap_val
`endif
);

  import param_counter_pkg::*;

  localparam int unsigned CW = WIDTH + 1;
  localparam logic [CW-1:0] MOD_LAST = CW'(MODULUS - 1);

  state_t           state;
  state_t           state_nx;
  logic             active;
  logic             tick_c;
  logic             at_wrap;
  logic [CW-1:0]    cnt_ext;
  logic [CW-1:0]    load_ext;
  logic [CW-1:0]    load_sat;
  logic [CW-1:0]    step_val;
  logic [WIDTH-1:0] count_nx;
  logic             tc_nx;
  logic             busy_nx;
  logic             done_nx;

  // Counting only happens while in RUN with run still requested.
  assign active = (state == RUN) && run;

  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .clear  (clr || load || !active),
    .enable (active),
    .div    (presc_div),
    .tick_c (tick_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; clr/load re-enter RUN or IDLE and drop DONE.
  always_comb begin
    state_nx = state;
    if (clr || load) begin
      state_nx = run ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: if (run) state_nx = RUN;
        RUN: begin
          if (!run) begin
            state_nx = IDLE;
          end else if (tick_c && at_wrap && one_shot) begin
            state_nx = DONE;
          end
        end
        DONE: if (!run) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Next count and flags, computed in WIDTH+1 bits so MODULUS=2**WIDTH fits.
  always_comb begin
    cnt_ext  = {1'b0, count};
    load_ext = {1'b0, load_val};
    load_sat = (load_ext > MOD_LAST) ? MOD_LAST : load_ext;
    if (dir == DIR_UP) begin
      at_wrap  = (cnt_ext == MOD_LAST);
      step_val = at_wrap ? '0 : cnt_ext + CW'(1);
    end else begin
      at_wrap  = (cnt_ext == '0);
      step_val = at_wrap ? MOD_LAST : cnt_ext - CW'(1);
    end
    count_nx = count;
    tc_nx    = 1'b0;
    if (clr) begin
      count_nx = '0;
    end else if (load) begin
      count_nx = WIDTH'(load_sat);
    end else if (tick_c) begin
      count_nx = WIDTH'(step_val);
      tc_nx    = at_wrap;
    end
    busy_nx = (state_nx == RUN);
    done_nx = (state_nx == DONE);
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_nx;
      tc    <= tc_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

`ifdef PARAM_COUNTER_CAPTURE_EN
  // Snapshot of the pre-update count; independent of clr/load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_val <= '0;
    end else if (capture) begin
      cap_val <= count;
    end
  end
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three instances (MODULUS 256, 10, 4) share
// one stimulus stream and are checked against a behavioural model.
module tb_param_updown_counter;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic       one_shot = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [3:0] presc_div = 4'd0;
  logic       capture = 1'b0;

  logic [7:0] c256; logic tc256, dn256, bz256;
  logic [3:0] c10;  logic tc10, dn10, bz10;
  logic [2:0] c4;   logic tc4, dn4, bz4;
`ifdef PARAM_COUNTER_CAPTURE_EN
  logic [7:0] cap256; logic [3:0] cap10; logic [2:0] cap4;
`endif

  int errors = 0;
  int checks = 0;

  int mod_of[3] = '{256, 10, 4};
  int wmask[3]  = '{255, 15, 7};
  int m_cnt[3]  = '{0, 0, 0};
  int m_st[3]   = '{0, 0, 0};
  int m_pre[3]  = '{0, 0, 0};
  bit m_tc[3]   = '{0, 0, 0};
  int m_cap = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE_W(4)) u256 (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .one_shot(one_shot),
    .clr(clr), .load(load), .load_val(load_val), .presc_div(presc_div),
    .count(c256), .tc(tc256), .done(dn256), .busy(bz256)
`ifdef PARAM_COUNTER_CAPTURE_EN
    , .capture(capture), .cap_val(cap256)
`endif
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE_W(4)) u10 (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .one_shot(one_shot),
    .clr(clr), .load(load), .load_val(load_val[3:0]), .presc_div(presc_div),
    .count(c10), .tc(tc10), .done(dn10), .busy(bz10)
`ifdef PARAM_COUNTER_CAPTURE_EN
    , .capture(capture), .cap_val(cap10)
`endif
  );

  param_updown_counter #(.WIDTH(3), .MODULUS(4), .PRESCALE_W(4)) u4 (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .one_shot(one_shot),
    .clr(clr), .load(load), .load_val(load_val[2:0]), .presc_div(presc_div),
    .count(c4), .tc(tc4), .done(dn4), .busy(bz4)
`ifdef PARAM_COUNTER_CAPTURE_EN
    , .capture(capture), .cap_val(cap4)
`endif
  );

  // Behavioural model: applies the inputs seen at a rising edge.
  task automatic model_step();
    int nxt;
    int v;
    int md;
`ifdef PARAM_COUNTER_CAPTURE_EN
    if (rst) m_cap = 0;
    else if (capture) m_cap = m_cnt[0];
`endif
    for (int i = 0; i < 3; i++) begin
      md = mod_of[i];
      if (rst) begin
        m_cnt[i] = 0; m_tc[i] = 0; m_st[i] = M_IDLE; m_pre[i] = 0;
      end else if (clr || load) begin
        v = int'(load_val) & wmask[i];
        m_cnt[i] = clr ? 0 : ((v >= md) ? md - 1 : v);
        m_tc[i] = 0;
        m_st[i] = run ? M_RUN : M_IDLE;
        m_pre[i] = 0;
      end else begin
        m_tc[i] = 0;
        nxt = m_st[i];
        if (m_st[i] == M_IDLE && run) nxt = M_RUN;
        if (m_st[i] != M_IDLE && !run) nxt = M_IDLE;
        if (m_st[i] == M_RUN && run) begin
          if (m_pre[i] >= int'(presc_div)) begin
            m_pre[i] = 0;
            if (!dir) m_cnt[i] = (m_cnt[i] + 1) % md;
            else      m_cnt[i] = (m_cnt[i] + md - 1) % md;
            if ((!dir && m_cnt[i] == 0) || (dir && m_cnt[i] == md - 1)) begin
              m_tc[i] = 1;
              if (one_shot) nxt = M_DONE;
            end
          end else begin
            m_pre[i] = m_pre[i] + 1;
          end
        end else begin
          m_pre[i] = 0;
        end
        m_st[i] = nxt;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [23:0] exp_vec();
    return {8'(m_cnt[0]), m_tc[0], m_st[0] == M_DONE, m_st[0] == M_RUN,
            4'(m_cnt[1]), m_tc[1], m_st[1] == M_DONE, m_st[1] == M_RUN,
            3'(m_cnt[2]), m_tc[2], m_st[2] == M_DONE, m_st[2] == M_RUN};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {c256, tc256, dn256, bz256, c10, tc10, dn10, bz10, c4, tc4, dn4, bz4};
  endfunction

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; clr = 1'b0; load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++;
      if (obs_vec() !== 24'h0) begin
        errors++;
        $display("FAIL reset: got %h expected %h", obs_vec(), 24'h0);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp_up();
    run = 1'b1; dir = 1'b0; presc_div = 4'd0; one_shot = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ramp_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      checks++;
      if (c256 !== 8'((k - 1) % 256) || tc256 !== (k == 257)) begin
        errors++;
        $display("FAIL ramp_const k=%0d: got count=%0d tc=%b expected count=%0d tc=%b",
                 k, c256, tc256, (k - 1) % 256, (k == 257));
      end
    end
  endtask

  task automatic test_down_load();
    int exp_seq[5] = '{3, 2, 1, 0, 9};
    run = 1'b0; dir = 1'b1; load = 1'b1; load_val = 8'd3;
    cyc();
    load = 1'b0; run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec() || c10 !== 4'(exp_seq[k]) || tc10 !== (k == 4)) begin
        errors++;
        $display("FAIL down_load k=%0d: got %h c10=%0d tc=%b expected %h c10=%0d tc=%b",
                 k, obs_vec(), c10, tc10, exp_vec(), exp_seq[k], (k == 4));
      end
    end
    load = 1'b1; load_val = 8'd12;
    cyc();
    load = 1'b0;
    checks++;
    if (obs_vec() !== exp_vec() || c10 !== 4'd9 || tc10 !== 1'b0 || c4 !== 3'd3) begin
      errors++;
      $display("FAIL load_sat: got %h c10=%0d c4=%0d expected %h c10=9 c4=3",
               obs_vec(), c10, c4, exp_vec());
    end
  endtask

  task automatic test_prescale();
    run = 1'b1; dir = 1'b0; presc_div = 4'd3; clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec() || c256 !== 8'(j / 4)) begin
        errors++;
        $display("FAIL prescale j=%0d: got %h c=%0d expected %h c=%0d",
                 j, obs_vec(), c256, exp_vec(), j / 4);
      end
    end
    run = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec() || c256 !== 8'd3) begin
        errors++;
        $display("FAIL prescale_hold j=%0d: got %h c=%0d expected %h c=3",
                 j, obs_vec(), c256, exp_vec());
      end
    end
    run = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec() || c256 !== 8'((j >= 5) ? 4 : 3)) begin
        errors++;
        $display("FAIL prescale_resume j=%0d: got %h c=%0d expected %h c=%0d",
                 j, obs_vec(), c256, exp_vec(), (j >= 5) ? 4 : 3);
      end
    end
    presc_div = 4'd0;
  endtask

  task automatic test_one_shot();
    int seq[8] = '{0, 1, 2, 3, 0, 0, 0, 0};
    run = 1'b0; one_shot = 1'b1; dir = 1'b0; presc_div = 4'd0; clr = 1'b1;
    cyc();
    clr = 1'b0; run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec() || c4 !== 3'(seq[k]) || tc4 !== (k == 4) ||
          dn4 !== (k >= 4) || bz4 !== (k < 4)) begin
        errors++;
        $display("FAIL one_shot k=%0d: got %h c4=%0d tc=%b done=%b busy=%b expected %h",
                 k, obs_vec(), c4, tc4, dn4, bz4, exp_vec());
      end
    end
    run = 1'b0;
    cyc();
    checks++;
    if (obs_vec() !== exp_vec() || dn4 !== 1'b0 || bz4 !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_idle: got %h done=%b busy=%b expected %h done=0 busy=0",
               obs_vec(), dn4, bz4, exp_vec());
    end
    run = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    checks++;
    if (dn4 !== 1'b1 || c4 !== 3'd0) begin
      errors++;
      $display("FAIL one_shot_again: got done=%b c4=%0d expected done=1 c4=0", dn4, c4);
    end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    checks++;
    if (obs_vec() !== exp_vec() || dn4 !== 1'b0 || bz4 !== 1'b1 || c4 !== 3'd0) begin
      errors++;
      $display("FAIL one_shot_clr: got %h done=%b busy=%b expected %h done=0 busy=1",
               obs_vec(), dn4, bz4, exp_vec());
    end
    one_shot = 1'b0;
  endtask

  task automatic test_clr_load();
    bit seen;
    run = 1'b1; dir = 1'b0; presc_div = 4'd0; load = 1'b1; load_val = 8'd5;
    cyc();
    clr = 1'b1; load = 1'b1; load_val = 8'd9;
    cyc();
    clr = 1'b0; load = 1'b0;
    checks++;
    if (obs_vec() !== exp_vec() || c256 !== 8'd0 || tc256 !== 1'b0) begin
      errors++;
      $display("FAIL clr_and_load: got %h c=%0d expected %h c=0", obs_vec(), c256, exp_vec());
    end
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc();
      if (c256 == 8'd7) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reach_seven: got count=%0d expected 7 within 20 cycles", c256);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0; run = 1'b0;
    checks++;
    if (obs_vec() !== 24'h0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", obs_vec(), 24'h0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst      = ($urandom % 100) == 0;
      clr      = ($urandom % 40) == 0;
      load     = ($urandom % 25) == 0;
      load_val = 8'($urandom);
      run      = ($urandom % 8) != 0;
      capture  = ($urandom % 4) == 0;
      if (($urandom % 20) == 0) dir = ~dir;
      if (($urandom % 30) == 0) one_shot = ~one_shot;
      if (($urandom % 50) == 0) presc_div = 4'($urandom_range(0, 3));
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random k=%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
`ifdef PARAM_COUNTER_CAPTURE_EN
      checks++;
      if (cap256 !== 8'(m_cap)) begin
        errors++;
        $display("FAIL random_cap k=%0d: got %0d expected %0d", k, cap256, m_cap);
      end
`endif
    end
    rst = 1'b0; clr = 1'b0; load = 1'b0; capture = 1'b0; run = 1'b0;
    cyc();
  endtask

`ifdef PARAM_COUNTER_CAPTURE_EN
  task automatic test_capture();
    run = 1'b0; load = 1'b1; load_val = 8'd42;
    cyc();
    capture = 1'b1; load = 1'b1; load_val = 8'd9;
    cyc();
    capture = 1'b0; load = 1'b0;
    checks++;
    if (cap256 !== 8'd42 || c256 !== 8'd9) begin
      errors++;
      $display("FAIL capture: got cap=%0d count=%0d expected cap=42 count=9", cap256, c256);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_up();
    test_down_load();
    test_prescale();
    test_one_shot();
    test_clr_load();
    test_random();
`ifdef PARAM_COUNTER_CAPTURE_EN
    test_capture();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
